// File: rtl/morph_pkg.sv
// Shared constants and types for the 3x3 binary morphology stage.
package morph_pkg;

  localparam logic OP_ERODE      = 1'b0;
  localparam logic OP_DILATE     = 1'b1;
  localparam int   MORPH_LATENCY = 2;
  localparam int   CNT_W         = 11;

  // One window column: {two lines up, one line up, current line}
  typedef logic [2:0] col_t;

  typedef struct packed {
    logic vsync;
    logic href;
    logic clken;
  } sync_t;

endpackage

// File: rtl/binary_line_buffer.sv
// One-bit line buffer: registered read-before-write, write data presented one
// cycle after we/addr so it can come from the same cycle's registered read data.
module binary_line_buffer #(
  parameter int DEPTH = 640,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic          din,
  output logic          dout
);

  logic          mem [DEPTH];
  logic          we_q;
  logic [AW-1:0] addr_q;

  // Deferred write to addr_q lands after the read of that address; the same
  // address is never read again before a full line has passed.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 1'b0;
      dout   <= 1'b0;
      we_q   <= 1'b0;
      addr_q <= '0;
    end else begin
      dout   <= we ? mem[addr] : 1'b0;
      we_q   <= we;
      addr_q <= addr;
      if (we_q) mem[addr_q] <= din;
    end
  end

endmodule

// File: rtl/binary_morph_3x3.sv
// Streaming 3x3 binary erosion/dilation on an edge bit stream, 2-clock latency.
// Define MORPH_CROSS_KERNEL_EN for a 5-tap cross kernel instead of the 3x3 square.
module binary_morph_3x3
  import morph_pkg::*;
#(
  parameter logic [CNT_W-1:0] IMG_HDISP = 11'd640,
  parameter logic [CNT_W-1:0] IMG_VDISP = 11'd480
) (
  input  logic clk,
  input  logic rst,
  input  logic op_sel,
  input  logic per_img_vsync,
  input  logic per_img_href,
  input  logic per_img_clken,
  input  logic per_img_bit,
  output logic post_img_vsync,
  output logic post_img_href,
  output logic post_img_clken,
  output logic post_img_bit
);

  localparam int               LB_DEPTH = int'(IMG_HDISP);
  localparam int               LB_AW    = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;
  localparam logic [CNT_W-1:0] BORDER   = CNT_W'(2);

  function automatic logic reduce_win(input logic op, input col_t c2, input col_t c1,
                                      input col_t c0);
`ifdef MORPH_CROSS_KERNEL_EN
    logic [4:0] taps;
    taps = {c1, c2[1], c0[1]};
`else
    logic [8:0] taps;
    taps = {c2, c1, c0};
`endif
    return (op == OP_DILATE) ? (|taps) : (&taps);
  endfunction

  logic             vsync_q, href_q;
  logic [CNT_W-1:0] x, y;
  logic             op_frame, frame_ok;
  logic             accept, lb_we, keep;
  logic             acc_p1, bit_p1, keep_p1;
  sync_t            sync_p [MORPH_LATENCY];
  logic             lb0_dout, lb1_dout;
  col_t             col0, win_c1, win_c2;
  logic             bit_p2;

  assign accept = per_img_clken & per_img_href;
  assign lb_we  = accept && (x < IMG_HDISP);
  assign keep   = frame_ok && (x >= BORDER) && (y >= BORDER) &&
                  (x < IMG_HDISP) && (y < IMG_VDISP);

  // Edge trackers follow the inputs through reset so a mid-frame release never fakes a vsync rise
  always_ff @(posedge clk) begin
    vsync_q <= per_img_vsync;
    href_q  <= per_img_href;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x        <= '0;
      y        <= '0;
      op_frame <= OP_ERODE;
      frame_ok <= 1'b0;
    end else begin
      if (!per_img_href)       x <= '0;
      else if (per_img_clken)  x <= x + 1'b1;
      if (!per_img_vsync)                y <= '0;
      else if (href_q && !per_img_href)  y <= y + 1'b1;
      if (per_img_vsync && !vsync_q) begin
        op_frame <= op_sel;
        frame_ok <= 1'b1;
      end
    end
  end

  // Stage 0 -> 1
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_p1 <= 1'b0;
      for (int i = 0; i < MORPH_LATENCY; i++) sync_p[i] <= '0;
    end else begin
      acc_p1    <= accept;
      sync_p[0] <= {per_img_vsync, per_img_href, per_img_clken};
      for (int i = 1; i < MORPH_LATENCY; i++) sync_p[i] <= sync_p[i-1];
    end
  end

  always_ff @(posedge clk) begin
    bit_p1  <= per_img_bit;
    keep_p1 <= keep;
    if (acc_p1) begin
      win_c1 <= col0;
      win_c2 <= win_c1;
    end
  end

  binary_line_buffer #(.DEPTH(LB_DEPTH), .AW(LB_AW)) u_lb1 (
    .clk  (clk),
    .rst  (rst),
    .we   (lb_we),
    .addr (x[LB_AW-1:0]),
    .din  (bit_p1),
    .dout (lb1_dout)
  );

  binary_line_buffer #(.DEPTH(LB_DEPTH), .AW(LB_AW)) u_lb0 (
    .clk  (clk),
    .rst  (rst),
    .we   (lb_we),
    .addr (x[LB_AW-1:0]),
    .din  (lb1_dout),
    .dout (lb0_dout)
  );

  assign col0 = {lb0_dout, lb1_dout, bit_p1};

  // Stage 1 -> 2
  always_ff @(posedge clk) begin
    if (rst)                   bit_p2 <= 1'b0;
    else if (acc_p1)           bit_p2 <= keep_p1 && reduce_win(op_frame, win_c2, win_c1, col0);
    else if (!sync_p[0].href)  bit_p2 <= 1'b0;
  end

  assign post_img_vsync = sync_p[MORPH_LATENCY-1].vsync;
  assign post_img_href  = sync_p[MORPH_LATENCY-1].href;
  assign post_img_clken = sync_p[MORPH_LATENCY-1].clken;
  assign post_img_bit   = bit_p2;

endmodule
